dmem_responder: RTL and testbench

Memory-side responder for the core's data port: it answers DREQ/DRW/DADDR/DWDATA with DRDATA from a single-port word array. It sits opposite the core in the top-level testbench/SoC wrapper. A secondary host port (bench loader/dumper) shares the array, and the core always has priority over it. Saturating access counters support performance checks.

---
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Core data port and host loader port of the data-memory responder.
interface dmem_responder_if #(
  parameter int AW   = 10,
  parameter int CNTW = 16
);
  logic            DREQ;
  logic            DRW;
  logic [29:0]     DADDR;
  logic [31:0]     DWDATA;
  logic [31:0]     DRDATA;
  logic            DERR;
  logic            HREQ;
  logic            HWE;
  logic [AW-1:0]   HADDR;
  logic [31:0]     HWDATA;
  logic            HACK;
  logic [31:0]     HRDATA;
  logic [CNTW-1:0] RDCNT;
  logic [CNTW-1:0] WRCNT;

  modport master (
    output DREQ, DRW, DADDR, DWDATA, HREQ, HWE, HADDR, HWDATA,
    input  DRDATA, DERR, HACK, HRDATA, RDCNT, WRCNT
  );

  modport slave (
    input  DREQ, DRW, DADDR, DWDATA, HREQ, HWE, HADDR, HWDATA,
    output DRDATA, DERR, HACK, HRDATA, RDCNT, WRCNT
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-port word array serving the core (1-cycle read, never stalls) and a host port.
// The host only gets the array on cycles with DREQ=0 and completes with a HACK pulse.
module dmem_responder #(
  parameter int AW   = 10,
  parameter int CNTW = 16
) (
  input logic             CLK,
  input logic             RST,
  dmem_responder_if.slave bus
);
  typedef enum logic {H_IDLE, H_RESP} h_state_e;

  localparam int              DEPTH   = 1 << AW;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [31:0]     mem_q [DEPTH];
  h_state_e        h_state_q, h_state_d;
  logic [31:0]     drdata_q, drdata_d;
  logic [31:0]     hrdata_q, hrdata_d;
  logic            derr_q, derr_d;
  logic [CNTW-1:0] rdcnt_q, rdcnt_d;
  logic [CNTW-1:0] wrcnt_q, wrcnt_d;

  logic            in_range;
  logic [AW-1:0]   core_idx;
  logic            core_rd;
  logic            core_wr;
  logic            host_go;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;

  assign in_range = (bus.DADDR[29:AW] == '0);
  assign core_idx = bus.DADDR[AW-1:0];
  assign core_rd  = bus.DREQ && !bus.DRW && in_range;
  assign core_wr  = bus.DREQ && bus.DRW && in_range;
  // Any core request, even out of range, takes the cycle away from the host.
  assign host_go  = (h_state_q == H_IDLE) && bus.HREQ && !bus.DREQ;

  always_comb begin
    h_state_d = h_state_q;
    drdata_d  = drdata_q;
    hrdata_d  = hrdata_q;
    derr_d    = bus.DREQ && !in_range;
    rdcnt_d   = rdcnt_q;
    wrcnt_d   = wrcnt_q;
    mem_we    = 1'b0;
    mem_waddr = core_idx;
    mem_wdata = bus.DWDATA;

    if (bus.DREQ && !bus.DRW) begin
      drdata_d = in_range ? mem_q[core_idx] : '0;
    end
    if (core_rd && (rdcnt_q != '1)) begin
      rdcnt_d = rdcnt_q + CNT_ONE;
    end
    if (core_wr) begin
      mem_we = 1'b1;
      if (wrcnt_q != '1) begin
        wrcnt_d = wrcnt_q + CNT_ONE;
      end
    end

    case (h_state_q)
      H_IDLE: begin
        if (host_go) begin
          h_state_d = H_RESP;
          if (bus.HWE) begin
            mem_we    = 1'b1;
            mem_waddr = bus.HADDR;
            mem_wdata = bus.HWDATA;
          end else begin
            hrdata_d = mem_q[bus.HADDR];
          end
        end
      end
      H_RESP:  h_state_d = H_IDLE;
      default: h_state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_state_q <= H_IDLE;
      drdata_q  <= '0;
      hrdata_q  <= '0;
      derr_q    <= 1'b0;
      rdcnt_q   <= '0;
      wrcnt_q   <= '0;
    end else begin
      h_state_q <= h_state_d;
      drdata_q  <= drdata_d;
      hrdata_q  <= hrdata_d;
      derr_q    <= derr_d;
      rdcnt_q   <= rdcnt_d;
      wrcnt_q   <= wrcnt_d;
    end
  end

  // Array contents survive reset; only new accesses are blocked while RST is high.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.DRDATA = drdata_q;
  assign bus.DERR   = derr_q;
  assign bus.HACK   = (h_state_q == H_RESP) && !RST;
  assign bus.HRDATA = hrdata_q;
  assign bus.RDCNT  = rdcnt_q;
  assign bus.WRCNT  = wrcnt_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven core accesses with a one-deep-latency scoreboard, plus host and reset sequences.
module tb_dmem_responder;
  localparam int AW      = 10;
  localparam int CNTW    = 4;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dmem_responder_if #(.AW(AW), .CNTW(CNTW)) bus ();
  dmem_responder #(.AW(AW), .CNTW(CNTW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  typedef struct {
    logic        req;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[11];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] hold_v = '0;
  int          exp_rd = 0;
  int          exp_wr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic drive_core(input logic req, input logic rw, input logic [29:0] a,
                            input logic [31:0] wd, input logic [31:0] er, input logic ee,
                            input int id);
    exp_t e;
    bus.DREQ   = req;
    bus.DRW    = rw;
    bus.DADDR  = a;
    bus.DWDATA = wd;
    if (req && !rw) hold_v = er;
    if (req && (a < 30'(1 << AW))) begin
      if (rw) exp_wr = sat_inc(exp_wr);
      else    exp_rd = sat_inc(exp_rd);
    end
    e.rdata = er;
    e.err   = ee;
    e.id    = id;
    sb.push_back(e);
  endtask

  task automatic idle_core();
    drive_core(1'b0, 1'b0, 30'd0, 32'd0, hold_v, 1'b0, -1);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("drdata_%0d", e.id), bus.DRDATA, e.rdata);
      check($sformatf("derr_%0d", e.id), {31'd0, bus.DERR}, {31'd0, e.err});
    end
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                         input int busy, input int exp_lat, input logic [31:0] exp_rdat,
                         input string nm);
    int lat;
    bit got;
    bus.HREQ   = 1'b1;
    bus.HWE    = we;
    bus.HADDR  = a;
    bus.HWDATA = wd;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      if (busy > 0) begin
        drive_core(1'b1, 1'b0, 30'd5, 32'd0, 32'hDEADBEEF, 1'b0, 200 + busy);
        busy--;
      end else begin
        idle_core();
      end
      tick();
      lat++;
      if (bus.HACK) got = 1'b1;
    end
    bus.HREQ = 1'b0;
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!we) check({nm, "_hrdata"}, bus.HRDATA, exp_rdat);
    idle_core();
    tick();
    check({nm, "_hack_drop"}, {31'd0, bus.HACK}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 30'd5,         32'd0,         32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 30'd3,         32'h12345678,  32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 30'd3,         32'd0,         32'h12345678, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 30'd3,         32'd0,         32'h12345678, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 30'h400,       32'd0,         32'h00000000, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 30'h400,       32'hBAD0BAD0,  32'h00000000, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 30'h3FF,       32'hA5A5A5A5,  32'h00000000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 30'h3FF,       32'd0,         32'hA5A5A5A5, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 30'd0,         32'd0,         32'h00000011, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 30'h3FFFFFFF,  32'd0,         32'h00000000, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 30'd1,         32'd0,         32'h22222222, 1'b0};

    RST = 1'b1;
    bus.DREQ = 1'b0; bus.DRW = 1'b0; bus.DADDR = '0; bus.DWDATA = '0;
    bus.HREQ = 1'b0; bus.HWE = 1'b0; bus.HADDR = '0; bus.HWDATA = '0;
    tick();
    tick();
    RST = 1'b0;
    check("rst_drdata", bus.DRDATA, 32'd0);
    check("rst_derr",   {31'd0, bus.DERR}, 32'd0);
    check("rst_hack",   {31'd0, bus.HACK}, 32'd0);
    check("rst_hrdata", bus.HRDATA, 32'd0);
    check("rst_rdcnt",  32'(bus.RDCNT), 32'd0);
    check("rst_wrcnt",  32'(bus.WRCNT), 32'd0);

    host_op(1'b1, 10'd5, 32'hDEADBEEF, 0, 1, 32'd0, "hwr5");
    host_op(1'b1, 10'd0, 32'h00000011, 0, 1, 32'd0, "hwr0");
    host_op(1'b1, 10'd1, 32'h22222222, 0, 1, 32'd0, "hwr1");
    host_op(1'b1, 10'd7, 32'h77777777, 0, 1, 32'd0, "hwr7");
    check("host_no_count_rd", 32'(bus.RDCNT), 32'd0);
    check("host_no_count_wr", 32'(bus.WRCNT), 32'd0);

    for (int i = 0; i < 11; i++) begin
      drive_core(vecs[i].req, vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_rdata, vecs[i].exp_err, i);
      tick();
    end
    idle_core();
    tick();
    check("tbl_rdcnt", 32'(bus.RDCNT), 32'd5);
    check("tbl_wrcnt", 32'(bus.WRCNT), 32'd2);

    // Out-of-range write to 0x400 must not alias onto index 0.
    host_op(1'b0, 10'd0, 32'd0, 0, 1, 32'h00000011, "hrd0");

    // Host read held off by three core cycles.
    host_op(1'b0, 10'd7, 32'd0, 3, 4, 32'h77777777, "hrd7_busy");
    check("busy_rdcnt", 32'(bus.RDCNT), 32'd8);

    for (int i = 0; i < 17; i++) begin
      drive_core(1'b1, 1'b0, 30'd5, 32'd0, 32'hDEADBEEF, 1'b0, 100 + i);
      tick();
      check($sformatf("sat_rdcnt_%0d", i), 32'(bus.RDCNT), 32'(exp_rd));
    end
    idle_core();
    tick();
    check("sat_rdcnt_final", 32'(bus.RDCNT), 32'hF);
    check("sat_wrcnt", 32'(bus.WRCNT), 32'(exp_wr));

    // Reset lands in the cycle after a host read was accepted.
    bus.HREQ  = 1'b1;
    bus.HWE   = 1'b0;
    bus.HADDR = 10'd7;
    idle_core();
    tick();
    RST      = 1'b1;
    bus.HREQ = 1'b0;
    #1;
    check("mid_rst_hack", {31'd0, bus.HACK}, 32'd0);
    tick();
    check("mid_rst_hack2",  {31'd0, bus.HACK}, 32'd0);
    check("mid_rst_hrdata", bus.HRDATA, 32'd0);
    check("mid_rst_drdata", bus.DRDATA, 32'd0);
    check("mid_rst_rdcnt",  32'(bus.RDCNT), 32'd0);
    RST    = 1'b0;
    hold_v = '0;
    exp_rd = 0;
    exp_wr = 0;
    host_op(1'b0, 10'd7, 32'd0, 0, 1, 32'h77777777, "post_rst_hrd7");
    host_op(1'b0, 10'd5, 32'd0, 0, 1, 32'hDEADBEEF, "post_rst_hrd5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
